// File: rtl/demux_bit_collector_pkg.sv
// Shared definitions for the bit collector: word/select widths and the
// two-state COLLECT/HOLD encoding.
package demux_bit_collector_pkg;
   localparam int WORD_W = 32;
   localparam int SEL_W  = 5;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;
endpackage

// File: rtl/demux_bit_collector_dec5to32.sv
// One-hot select decoder.
//   en     : when low, output is all zeros
//   sel    : bit index 0..31
//   onehot : bit sel set when en is high
module dec5to32
   import demux_bit_collector_pkg::*;
(
   input  logic              en,
   input  logic [SEL_W-1:0]  sel,
   output logic [WORD_W-1:0] onehot
);
   for (genvar i = 0; i < WORD_W; i++) begin : g_bit
      assign onehot[i] = en && (sel == SEL_W'(i));
   end
endmodule

// File: rtl/demux_bit_collector.sv
// Scatters single bits into a 32-bit word by index. Once every index has been
// written the word is held (word_valid) until the consumer takes it.
//   clk, rst          : clock, synchronous active-high reset
//   in_bit/sel        : data bit and its destination index
//   in_valid/in_ready : input handshake (ready only while collecting)
//   flush             : discard the partial or held word
//   word/word_valid   : assembled word, valid while held
//   word_ready        : consumer takes the held word
//   fill_mask         : indices written so far in the current word
//   dup_err           : one-cycle pulse when a duplicate index is dropped
//   OVERWRITE         : 1 = duplicate index replaces, 0 = dropped and flagged
module demux_bit_collector
   import demux_bit_collector_pkg::*;
#(
   parameter bit OVERWRITE = 1'b1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_bit,
   input  logic [SEL_W-1:0]  sel,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   output logic [WORD_W-1:0] word,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [WORD_W-1:0] fill_mask,
   output logic              dup_err
);
   state_t            state, state_nxt;
   logic [WORD_W-1:0] hit;
   logic              accept, filled, wr_en, dup, clear;

   assign in_ready   = (state == COLLECT);
   assign word_valid = (state == HOLD);

   assign accept = in_valid && (state == COLLECT);
   assign filled = fill_mask[sel];
   // With OVERWRITE=0 a repeat index is refused at the decoder, so the word
   // and mask simply see no write.
   assign wr_en  = accept && (OVERWRITE || !filled);
   assign dup    = accept && !OVERWRITE && filled;
   assign clear  = flush || ((state == HOLD) && word_ready);

   dec5to32 u_dec (
      .en     (wr_en),
      .sel    (sel),
      .onehot (hit)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (wr_en && (&(fill_mask | hit))) state_nxt = HOLD;
         HOLD:    if (word_ready) state_nxt = COLLECT;
         default: state_nxt = COLLECT;
      endcase
      if (flush) state_nxt = COLLECT;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= COLLECT;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         word      <= '0;
         fill_mask <= '0;
      end else if (wr_en) begin
         word      <= (word & ~hit) | (hit & {WORD_W{in_bit}});
         fill_mask <= fill_mask | hit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) dup_err <= 1'b0;
      else              dup_err <= dup;
   end
endmodule

// File: tb/tb_demux_bit_collector.sv
// Directed bench for demux_bit_collector. Two instances share the stimulus:
// dut_ow (OVERWRITE=1) and dut_nd (OVERWRITE=0, duplicates dropped).
module tb_demux_bit_collector;
   logic        clk = 1'b0;
   logic        rst, in_bit, in_valid, flush, word_ready;
   logic [4:0]  sel;
   logic        ow_ready, ow_valid, ow_dup;
   logic [31:0] ow_word, ow_mask;
   logic        nd_ready, nd_valid, nd_dup;
   logic [31:0] nd_word, nd_mask;
   int          errors = 0;
   int          checks = 0;
   int          perm[32];

   always #5 clk = ~clk;

   demux_bit_collector #(.OVERWRITE(1'b1)) dut_ow (
      .clk(clk), .rst(rst), .in_bit(in_bit), .sel(sel), .in_valid(in_valid),
      .in_ready(ow_ready), .flush(flush), .word(ow_word), .word_valid(ow_valid),
      .word_ready(word_ready), .fill_mask(ow_mask), .dup_err(ow_dup)
   );

   demux_bit_collector #(.OVERWRITE(1'b0)) dut_nd (
      .clk(clk), .rst(rst), .in_bit(in_bit), .sel(sel), .in_valid(in_valid),
      .in_ready(nd_ready), .flush(flush), .word(nd_word), .word_valid(nd_valid),
      .word_ready(word_ready), .fill_mask(nd_mask), .dup_err(nd_dup)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the edge they result from.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int s, input logic b);
      in_valid = 1'b1;
      sel      = 5'(s);
      in_bit   = b;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; flush = 1'b0;
      word_ready = 1'b0; sel = '0;
      tick(); tick();
      rst = 1'b0;

      // reset state
      chk("rst_valid", 32'(nd_valid), 32'd0);
      chk("rst_ready", 32'(nd_ready), 32'd1);
      chk("rst_word",  nd_word, 32'h0);
      chk("rst_mask",  nd_mask, 32'h0);
      chk("rst_dup",   32'(nd_dup), 32'd0);

      // ascending fill, in_bit = sel[0]
      for (int i = 0; i < 32; i++) begin
         put(i, i[0]);
         if (i == 30) begin
            chk("asc_valid_30", 32'(nd_valid), 32'd0);
            chk("asc_mask_30",  nd_mask, 32'h7FFF_FFFF);
         end
      end
      chk("asc_valid", 32'(nd_valid), 32'd1);
      chk("asc_word",  nd_word, 32'hAAAA_AAAA);
      chk("asc_ready", 32'(nd_ready), 32'd0);
      chk("asc_word_ow", ow_word, 32'hAAAA_AAAA);
      word_ready = 1'b1; tick(); word_ready = 1'b0;
      chk("asc_take_word",  nd_word, 32'h0);
      chk("asc_take_ready", 32'(nd_ready), 32'd1);

      // random-order fill, consumer stalls 5 cycles
      for (int i = 0; i < 32; i++) perm[i] = i;
      for (int i = 31; i > 0; i--) begin
         int j, t;
         j = int'($urandom_range(i, 0));
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < 32; i++) put(perm[i], 1'b1);
      chk("rnd_dup", 32'(nd_dup), 32'd0);
      for (int k = 0; k < 5; k++) begin
         chk("rnd_hold_valid", 32'(nd_valid), 32'd1);
         chk("rnd_hold_word",  nd_word, 32'hFFFF_FFFF);
         tick();
      end
      word_ready = 1'b1; tick(); word_ready = 1'b0;
      chk("rnd_take_word",  nd_word, 32'h0);
      chk("rnd_take_mask",  nd_mask, 32'h0);
      chk("rnd_take_ready", 32'(nd_ready), 32'd1);
      chk("rnd_take_valid", 32'(nd_valid), 32'd0);

      // duplicate index handling
      put(3, 1'b1);
      chk("dup_first", 32'(nd_dup), 32'd0);
      put(3, 1'b0);
      chk("dup_nd_pulse", 32'(nd_dup), 32'd1);
      chk("dup_nd_word",  nd_word, 32'h0000_0008);
      chk("dup_nd_mask",  nd_mask, 32'h0000_0008);
      chk("dup_nd_ready", 32'(nd_ready), 32'd1);
      chk("dup_ow_pulse", 32'(ow_dup), 32'd0);
      chk("dup_ow_word",  ow_word, 32'h0);
      chk("dup_ow_mask",  ow_mask, 32'h0000_0008);
      tick();
      chk("dup_nd_end", 32'(nd_dup), 32'd0);
      flush = 1'b1; tick(); flush = 1'b0;
      chk("dup_flush_mask", nd_mask, 32'h0);

      // flush beats a simultaneous accept
      for (int i = 0; i < 16; i++) put(i, 1'b1);
      chk("fl_half_mask", nd_mask, 32'h0000_FFFF);
      flush = 1'b1; in_valid = 1'b1; sel = 5'd16; in_bit = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_mask", nd_mask, 32'h0);
      chk("fl_word", nd_word, 32'h0);
      for (int i = 16; i < 32; i++) put(i, 1'b1);
      chk("fl_upper_valid", 32'(nd_valid), 32'd0);
      chk("fl_upper_mask",  nd_mask, 32'hFFFF_0000);
      for (int i = 0; i < 16; i++) put(i, 1'b1);
      chk("fl_full_valid", 32'(nd_valid), 32'd1);
      chk("fl_full_word",  nd_word, 32'hFFFF_FFFF);

      // in_valid ignored while holding, then reset mid-hold
      for (int k = 0; k < 3; k++) begin
         put(5, 1'b0);
         chk("hold_word",    nd_word, 32'hFFFF_FFFF);
         chk("hold_word_ow", ow_word, 32'hFFFF_FFFF);
         chk("hold_dup",     32'(nd_dup), 32'd0);
         chk("hold_valid",   32'(nd_valid), 32'd1);
      end
      rst = 1'b1; word_ready = 1'b1; tick(); rst = 1'b0; word_ready = 1'b0;
      chk("hrst_valid", 32'(nd_valid), 32'd0);
      chk("hrst_word",  nd_word, 32'h0);
      chk("hrst_ready", 32'(nd_ready), 32'd1);
      chk("hrst_mask",  ow_mask, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/demux_bit_collector.md
DEMUX_BIT_COLLECTOR -- requirements
Module: demux_bit_collector

Interface
REQ-001 SHALL have parameter OVERWRITE, default 1: 1 = a write to an already-filled bit replaces it; 0 = it is dropped and flagged.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_bit  input  1  data bit to scatter.
REQ-005 SHALL have port sel  input  5  destination bit index 0..31 within word.
REQ-006 SHALL have port in_valid  input  1  in_bit/sel valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block can accept a bit this cycle.
REQ-008 SHALL have port flush  input  1  discard partial word, clear fill state.
REQ-009 SHALL have port word  output  32  assembled word, bit i = last in_bit accepted with sel=i.
REQ-010 SHALL have port word_valid  output  1  word complete and held.
REQ-011 SHALL have port word_ready  input  1  consumer takes word this cycle.
REQ-012 SHALL have port fill_mask  output  32  bit i set once index i has been written in current word.
REQ-013 SHALL have port dup_err  output  1  one-cycle pulse: duplicate index dropped (OVERWRITE=0 only).

Function
REQ-014 SHALL implement two states: COLLECT (in_ready=1, word_valid=0) and HOLD (in_ready=0, word_valid=1).
REQ-015 Accept SHALL occur on a clock edge in COLLECT with in_valid=1 and in_ready=1; word[sel] <= in_bit, fill_mask[sel] <= 1; all other bits unchanged.
REQ-016 Decode of sel SHALL be one-hot 5-to-32; exactly one word bit and one mask bit may change per accept.
REQ-017 When an accept makes fill_mask all-ones, state SHALL be HOLD on the next cycle (word_valid high 1 cycle after the 32nd distinct index accepted).
REQ-018 In HOLD, word and fill_mask SHALL stay stable; in_valid SHALL be ignored (no write, no dup_err).
REQ-019 In HOLD with word_ready=1, next cycle SHALL be COLLECT with word=0, fill_mask=0.
REQ-020 word_valid SHALL stay high until word_ready; never deasserts without handshake except via rst or flush.
REQ-021 OVERWRITE=1: accept at a filled index SHALL overwrite word[sel]; mask unchanged; dup_err stays 0.
REQ-022 OVERWRITE=0: in_valid at a filled index in COLLECT SHALL leave word unchanged and pulse dup_err for exactly the following cycle; in_ready stays 1.
REQ-023 flush=1 SHALL, next cycle, force COLLECT, word=0, fill_mask=0, from either state; flush has priority over a simultaneous accept or word_ready.
REQ-024 Indices may arrive in any order; completion depends only on fill_mask, not on arrival count.
REQ-025 Outputs SHALL be registered or decoded from state; no combinational path from in_valid/sel to in_ready or word_valid.

Reset
REQ-026 On rst=1 at a clock edge: state=COLLECT, word=0, fill_mask=0, word_valid=0, dup_err=0, in_ready=1 from the next cycle.
REQ-027 rst SHALL override flush, accept and word_ready; a partial or held word is discarded.

Structure
REQ-028 Shared package SHALL hold WORD_W=32, SEL_W=5, and the COLLECT/HOLD state encoding.
REQ-029 The one-hot decode SHALL be a sub-module dec5to32 (5-bit in, 32-bit one-hot out, enable input).
REQ-030 Remaining logic (state register, word/mask registers, dup detect) SHALL live in demux_bit_collector.

Verification
REQ-031 Reset, then sel=0..31 ascending, in_bit=sel[0] -> word_valid high cycle after sel=31, word=0xAAAAAAAA, in_ready=0.
REQ-032 Random-order 32 distinct indices with in_bit=1, word_ready held 0 for 5 cycles -> word=0xFFFFFFFF stable, word_valid high all 5 cycles; word_ready=1 -> next cycle word=0, fill_mask=0, in_ready=1.
REQ-033 OVERWRITE=0: write sel=3 bit 1, then sel=3 bit 0 -> word[3]=1, dup_err pulses one cycle, fill_mask=0x00000008; OVERWRITE=1 same stimulus -> word[3]=0, dup_err=0.
REQ-034 Write sel=0..15, then flush=1 with in_valid=1, sel=16 -> next cycle fill_mask=0, word=0; completion then requires 32 fresh indices.
REQ-035 In HOLD drive in_valid=1, sel=5, in_bit=0 for 3 cycles -> word unchanged; rst=1 mid-HOLD -> next cycle word_valid=0, word=0, in_ready=1.
